control_sequencer: RTL and testbench

- Hardwired control unit that drives every enable, bus-select and memory strobe of the 32-bit datapath.
- Steps fetch → decode → execute using one state register plus a step counter, reading instruction fields from the datapath IR.
- Handshakes with memory through mem_ready so RAM may insert wait states.
- Supersedes bench-driven control vectors; instantiated beside the datapath at system top.

---
 rtl/cu_pkg.sv | 90 +++++++++
 rtl/reg_select_decode.sv | 36 +++
 rtl/control_sequencer.sv | 258 +++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the hardwired control unit: opcode map, FSM state,
// step numbers, IR field positions and the instruction-class decode.
package cu_pkg;

  localparam int IR_W      = 32;
  localparam int OP_W      = 5;
  localparam int RF_W      = 4;
  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_LSB = 15;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01000;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b01001;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01010;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01011;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01101;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01110;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10001;
  localparam logic [OP_W-1:0] OP_IN   = 5'b10101;
  localparam logic [OP_W-1:0] OP_OUT  = 5'b10110;
  localparam logic [OP_W-1:0] OP_MFHI = 5'b10111;
  localparam logic [OP_W-1:0] OP_MFLO = 5'b11000;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11001;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11010;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;
  localparam logic [2:0] T5 = 3'd5;
  localparam logic [2:0] T6 = 3'd6;
  localparam logic [2:0] T7 = 3'd7;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_FETCH,
    ST_EXEC,
    ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    CL_NONE,
    CL_RR,
    CL_UNARY,
    CL_IMM,
    CL_LDI,
    CL_LD,
    CL_ST,
    CL_MULDIV,
    CL_MFHI,
    CL_MFLO,
    CL_IN,
    CL_OUT,
    CL_HALT
  } op_class_t;

  // nop and every unassigned opcode fall through to CL_NONE
  function automatic op_class_t op_class(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: return CL_RR;
      OP_NEG, OP_NOT:                 return CL_UNARY;
      OP_ADDI, OP_ANDI, OP_ORI:       return CL_IMM;
      OP_LDI:                         return CL_LDI;
      OP_LD:                          return CL_LD;
      OP_ST:                          return CL_ST;
      OP_MUL, OP_DIV:                 return CL_MULDIV;
      OP_MFHI:                        return CL_MFHI;
      OP_MFLO:                        return CL_MFLO;
      OP_IN:                          return CL_IN;
      OP_OUT:                         return CL_OUT;
      OP_HALT:                        return CL_HALT;
      default:                        return CL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/reg_select_decode.sv
// Turns the chosen IR register field into one-hot register in/out enables.
// Purely combinational, zero latency, no backpressure.
module reg_select_decode
  import cu_pkg::*;
#(
  parameter int NREG = 16
) (
  input  logic [RF_W-1:0] Ra,
  input  logic [RF_W-1:0] Rb,
  input  logic [RF_W-1:0] Rc,
  input  logic            Gra,
  input  logic            Grb,
  input  logic            Grc,
  input  logic            Rin,
  input  logic            Rout,
  output logic [NREG-1:0] reg_in,
  output logic [NREG-1:0] reg_out
);

  logic [RF_W-1:0] sel;
  logic            any_g;
  logic [NREG-1:0] onehot;

  always_comb begin
    sel = '0;
    if (Gra)      sel = Ra;
    else if (Grb) sel = Rb;
    else if (Grc) sel = Rc;
  end

  assign any_g   = Gra | Grb | Grc;
  assign onehot  = NREG'(1) << sel;
  assign reg_in  = (Rin  && any_g) ? onehot : '0;
  assign reg_out = (Rout && any_g) ? onehot : '0;

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute control unit; strobes decode combinationally from state+step+IR.
// Fetch 3 cycles, execute 1-5 cycles; T1, ld T6 and st T7 stall until mem_ready.
module control_sequencer
  import cu_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int NREG = 16
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [IR_W-1:0] ir,
  input  logic            mem_ready,
  output logic [NREG-1:0] reg_in,
  output logic [NREG-1:0] reg_out,
  output logic            IRin,
  output logic            PCin,
  output logic            RYin,
  output logic            RZin,
  output logic            MARin,
  output logic            MDRin,
  output logic            HIin,
  output logic            LOin,
  output logic            Outport_in,
  output logic            HIout,
  output logic            LOout,
  output logic            Zhi_out,
  output logic            Zlo_out,
  output logic            PCout,
  output logic            MDRout,
  output logic            Inport_out,
  output logic            Cout,
  output logic            IncPC,
  output logic            BAout,
  output logic            Mem_read,
  output logic            mem_write,
  output logic [OPW-1:0]  opcode,
  output logic            run
);

  state_t          state, state_nxt;
  logic [2:0]      step, step_nxt;
  logic [OP_W-1:0] op;
  logic [RF_W-1:0] ra, rb, rc;
  op_class_t       cls;
  logic            gra, grb, grc, rin, rout;
  logic            fin, mem_wait;
  logic            unused_ir_bits;

  assign op  = ir[IR_OP_LSB +: OP_W];
  assign ra  = ir[IR_RA_LSB +: RF_W];
  assign rb  = ir[IR_RB_LSB +: RF_W];
  assign rc  = ir[IR_RC_LSB +: RF_W];
  assign cls = op_class(op);
  assign unused_ir_bits = ^ir[IR_RC_LSB-1:0];

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= ST_RESET;
      step  <= T0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    step_nxt   = step;
    IRin       = 1'b0;
    PCin       = 1'b0;
    RYin       = 1'b0;
    RZin       = 1'b0;
    MARin      = 1'b0;
    MDRin      = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    Outport_in = 1'b0;
    HIout      = 1'b0;
    LOout      = 1'b0;
    Zhi_out    = 1'b0;
    Zlo_out    = 1'b0;
    PCout      = 1'b0;
    MDRout     = 1'b0;
    Inport_out = 1'b0;
    Cout       = 1'b0;
    IncPC      = 1'b0;
    BAout      = 1'b0;
    Mem_read   = 1'b0;
    mem_write  = 1'b0;
    opcode     = '0;
    run        = 1'b0;
    gra        = 1'b0;
    grb        = 1'b0;
    grc        = 1'b0;
    rin        = 1'b0;
    rout       = 1'b0;
    fin        = 1'b0;
    mem_wait   = 1'b0;

    unique case (state)
      ST_RESET: begin
        state_nxt = ST_FETCH;
        step_nxt  = T0;
      end

      ST_FETCH: begin
        run = 1'b1;
        case (step)
          T0: begin
            PCout    = 1'b1;
            MARin    = 1'b1;
            IncPC    = 1'b1;
            RZin     = 1'b1;
            step_nxt = T1;
          end
          T1: begin
            Zlo_out  = 1'b1;
            PCin     = 1'b1;
            Mem_read = 1'b1;
            MDRin    = 1'b1;
            if (mem_ready) step_nxt = T2;
          end
          default: begin
            MDRout    = 1'b1;
            IRin      = 1'b1;
            state_nxt = ST_EXEC;
            step_nxt  = T3;
          end
        endcase
      end

      ST_EXEC: begin
        run      = 1'b1;
        step_nxt = step + 3'd1;
        // ld/ldi/st use the ALU only for base+offset address arithmetic
        if (cls == CL_LD || cls == CL_LDI || cls == CL_ST) opcode = OPW'(OP_ADD);
        else                                               opcode = OPW'(op);

        case (step)
          T3: begin
            case (cls)
              CL_RR, CL_UNARY, CL_IMM: begin
                grb = 1'b1; rout = 1'b1; RYin = 1'b1;
              end
              CL_LDI, CL_LD, CL_ST: begin
                grb = 1'b1; rout = 1'b1; BAout = 1'b1; RYin = 1'b1;
              end
              CL_MULDIV: begin
                gra = 1'b1; rout = 1'b1; RYin = 1'b1;
              end
              CL_MFHI: begin
                HIout = 1'b1; gra = 1'b1; rin = 1'b1; fin = 1'b1;
              end
              CL_MFLO: begin
                LOout = 1'b1; gra = 1'b1; rin = 1'b1; fin = 1'b1;
              end
              CL_IN: begin
                Inport_out = 1'b1; gra = 1'b1; rin = 1'b1; fin = 1'b1;
              end
              CL_OUT: begin
                gra = 1'b1; rout = 1'b1; Outport_in = 1'b1; fin = 1'b1;
              end
              CL_HALT: begin
                state_nxt = ST_HALT;
                step_nxt  = T0;
              end
              default: fin = 1'b1;
            endcase
          end

          T4: begin
            case (cls)
              CL_RR: begin
                grc = 1'b1; rout = 1'b1; RZin = 1'b1;
              end
              CL_UNARY, CL_MULDIV: begin
                grb = 1'b1; rout = 1'b1; RZin = 1'b1;
              end
              CL_IMM, CL_LDI, CL_LD, CL_ST: begin
                Cout = 1'b1; RZin = 1'b1;
              end
              default: fin = 1'b1;
            endcase
          end

          T5: begin
            case (cls)
              CL_RR, CL_UNARY, CL_IMM, CL_LDI: begin
                Zlo_out = 1'b1; gra = 1'b1; rin = 1'b1; fin = 1'b1;
              end
              CL_LD, CL_ST: begin
                Zlo_out = 1'b1; MARin = 1'b1;
              end
              CL_MULDIV: begin
                Zlo_out = 1'b1; LOin = 1'b1;
              end
              default: fin = 1'b1;
            endcase
          end

          T6: begin
            case (cls)
              CL_LD: begin
                Mem_read = 1'b1; MDRin = 1'b1; mem_wait = 1'b1;
              end
              CL_ST: begin
                gra = 1'b1; rout = 1'b1; MDRin = 1'b1;
              end
              CL_MULDIV: begin
                Zhi_out = 1'b1; HIin = 1'b1; fin = 1'b1;
              end
              default: fin = 1'b1;
            endcase
          end

          default: begin
            case (cls)
              CL_LD: begin
                MDRout = 1'b1; gra = 1'b1; rin = 1'b1; fin = 1'b1;
              end
              CL_ST: begin
                mem_write = 1'b1; mem_wait = 1'b1; fin = mem_ready;
              end
              default: fin = 1'b1;
            endcase
          end
        endcase

        if (fin) begin
          state_nxt = ST_FETCH;
          step_nxt  = T0;
        end else if (mem_wait && !mem_ready) begin
          step_nxt = step;
        end
      end

      ST_HALT: begin
        state_nxt = ST_HALT;
      end
    endcase
  end

  reg_select_decode #(
    .NREG (NREG)
  ) u_reg_select_decode (
    .Ra      (ra),
    .Rb      (rb),
    .Rc      (rc),
    .Gra     (gra),
    .Grb     (grb),
    .Grc     (grc),
    .Rin     (rin),
    .Rout    (rout),
    .reg_in  (reg_in),
    .reg_out (reg_out)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: per-cycle expected control vectors are queued as stimulus is applied
// and compared against the packed DUT outputs on the falling edge.
module tb_control_sequencer;

  logic        clock;
  logic        clear;
  logic [31:0] ir;
  logic        mem_ready;
  logic [15:0] reg_in, reg_out;
  logic IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in;
  logic HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout;
  logic IncPC, BAout, Mem_read, mem_write;
  logic [4:0]  opcode;
  logic        run;

  control_sequencer #(.OPW(5), .NREG(16)) dut (
    .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready),
    .reg_in(reg_in), .reg_out(reg_out),
    .IRin(IRin), .PCin(PCin), .RYin(RYin), .RZin(RZin), .MARin(MARin), .MDRin(MDRin),
    .HIin(HIin), .LOin(LOin), .Outport_in(Outport_in),
    .HIout(HIout), .LOout(LOout), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out), .PCout(PCout),
    .MDRout(MDRout), .Inport_out(Inport_out), .Cout(Cout),
    .IncPC(IncPC), .BAout(BAout), .Mem_read(Mem_read), .mem_write(mem_write),
    .opcode(opcode), .run(run)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [63:0] M_RUN   = 64'h1 << 37;
  localparam logic [63:0] M_IRIN  = 64'h1 << 38;
  localparam logic [63:0] M_PCIN  = 64'h1 << 39;
  localparam logic [63:0] M_RYIN  = 64'h1 << 40;
  localparam logic [63:0] M_RZIN  = 64'h1 << 41;
  localparam logic [63:0] M_MARIN = 64'h1 << 42;
  localparam logic [63:0] M_MDRIN = 64'h1 << 43;
  localparam logic [63:0] M_HIIN  = 64'h1 << 44;
  localparam logic [63:0] M_LOIN  = 64'h1 << 45;
  localparam logic [63:0] M_OUTP  = 64'h1 << 46;
  localparam logic [63:0] M_HIOUT = 64'h1 << 47;
  localparam logic [63:0] M_LOOUT = 64'h1 << 48;
  localparam logic [63:0] M_ZHI   = 64'h1 << 49;
  localparam logic [63:0] M_ZLO   = 64'h1 << 50;
  localparam logic [63:0] M_PCOUT = 64'h1 << 51;
  localparam logic [63:0] M_MDROUT= 64'h1 << 52;
  localparam logic [63:0] M_INP   = 64'h1 << 53;
  localparam logic [63:0] M_COUT  = 64'h1 << 54;
  localparam logic [63:0] M_INCPC = 64'h1 << 55;
  localparam logic [63:0] M_BA    = 64'h1 << 56;
  localparam logic [63:0] M_MRD   = 64'h1 << 57;
  localparam logic [63:0] M_MWR   = 64'h1 << 58;

  logic [63:0] obs;
  assign obs = {5'b0, mem_write, Mem_read, BAout, IncPC, Cout, Inport_out, MDRout, PCout,
                Zlo_out, Zhi_out, LOout, HIout, Outport_in, LOin, HIin, MDRin, MARin,
                RZin, RYin, PCin, IRin, run, opcode, reg_out, reg_in};

  typedef struct {
    logic        clr;
    logic        mr;
    logic [31:0] irv;
    logic [63:0] exp;
  } ent_t;

  ent_t        stim_q[$];
  string       stag_q[$];
  logic [63:0] exp_q[$];
  string       etag_q[$];
  int          n_tot = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tot++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] ri(input int r);
    return 64'h1 << r;
  endfunction
  function automatic logic [63:0] ro(input int r);
    return 64'h1 << (16 + r);
  endfunction
  function automatic logic [31:0] enc(input logic [4:0] o, input logic [3:0] a,
                                      input logic [3:0] b, input logic [3:0] c);
    return {o, a, b, c, 15'd0};
  endfunction

  task automatic put(input logic clr, input logic mr, input logic [31:0] irv,
                     input logic [63:0] e, input string tag);
    ent_t x;
    x.clr = clr; x.mr = mr; x.irv = irv; x.exp = e;
    stim_q.push_back(x);
    stag_q.push_back(tag);
  endtask

  task automatic fetch(input logic [31:0] irv, input int waits);
    put(1'b1, 1'b1, irv, M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_RZIN, "t0");
    for (int w = 0; w < waits; w++)
      put(1'b1, 1'b0, irv, M_RUN | M_ZLO | M_PCIN | M_MRD | M_MDRIN, "t1_wait");
    put(1'b1, 1'b1, irv, M_RUN | M_ZLO | M_PCIN | M_MRD | M_MDRIN, "t1");
    put(1'b1, 1'b0, irv, M_RUN | M_MDROUT | M_IRIN, "t2");
  endtask

  // execute-step expectation: run high, opcode = IR op except address-compute classes use add
  task automatic ex(input logic [31:0] irv, input logic mr, input logic [63:0] m,
                    input string tag);
    logic [4:0] o;
    o = irv[31:27];
    if (o <= 5'd2) o = 5'd3;
    put(1'b1, mr, irv, m | M_RUN | {27'd0, o, 32'd0}, tag);
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      logic [63:0] e;
      string       t;
      e = exp_q.pop_front();
      t = etag_q.pop_front();
      chk(t, obs, e);
      chk({t, "_onebus"},
          64'($countones({HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout,
                          reg_out}) <= 1), 64'd1);
    end
  end

  initial begin
    logic [31:0] i_add, i_ld, i_st, i_mul, i_neg, i_addi, i_ldi, i_mfhi, i_in, i_out;
    logic [31:0] i_nop, i_undef, i_halt, i_st2;
    ent_t  e;
    string t;

    clear = 1'b0; mem_ready = 1'b0; ir = 32'd0;

    i_add   = enc(5'd3, 4'd3, 4'd1, 4'd2);
    i_ld    = enc(5'd0, 4'd2, 4'd0, 4'd0) | 32'h55;
    i_st    = enc(5'd2, 4'd6, 4'd4, 4'd0) | 32'h20;
    i_mul   = enc(5'd14, 4'd5, 4'd6, 4'd0);
    i_neg   = enc(5'd16, 4'd4, 4'd8, 4'd0);
    i_addi  = enc(5'd11, 4'd1, 4'd2, 4'd0) | 32'h7;
    i_ldi   = enc(5'd1, 4'd5, 4'd9, 4'd0) | 32'h3;
    i_mfhi  = enc(5'd23, 4'd7, 4'd0, 4'd0);
    i_in    = enc(5'd21, 4'd10, 4'd0, 4'd0);
    i_out   = enc(5'd22, 4'd9, 4'd0, 4'd0);
    i_nop   = enc(5'd25, 4'd0, 4'd0, 4'd0);
    i_undef = enc(5'd31, 4'd3, 4'd3, 4'd3);
    i_halt  = enc(5'd26, 4'd0, 4'd0, 4'd0);
    i_st2   = enc(5'd2, 4'd11, 4'd12, 4'd0);

    for (int k = 0; k < 3; k++) put(1'b0, 1'b0, 32'd0, 64'd0, "rst");
    put(1'b1, 1'b1, 32'd0, 64'd0, "rst_rel");

    fetch(i_add, 0);
    ex(i_add, 1'b1, ro(1) | M_RYIN, "add_t3");
    ex(i_add, 1'b1, ro(2) | M_RZIN, "add_t4");
    ex(i_add, 1'b1, M_ZLO | ri(3), "add_t5");

    fetch(i_ld, 0);
    ex(i_ld, 1'b1, ro(0) | M_BA | M_RYIN, "ld_t3");
    ex(i_ld, 1'b1, M_COUT | M_RZIN, "ld_t4");
    ex(i_ld, 1'b1, M_ZLO | M_MARIN, "ld_t5");
    ex(i_ld, 1'b0, M_MRD | M_MDRIN, "ld_t6_w0");
    ex(i_ld, 1'b0, M_MRD | M_MDRIN, "ld_t6_w1");
    ex(i_ld, 1'b1, M_MRD | M_MDRIN, "ld_t6");
    ex(i_ld, 1'b1, M_MDROUT | ri(2), "ld_t7");

    fetch(i_st, 1);
    ex(i_st, 1'b0, ro(4) | M_BA | M_RYIN, "st_t3");
    ex(i_st, 1'b0, M_COUT | M_RZIN, "st_t4");
    ex(i_st, 1'b0, M_ZLO | M_MARIN, "st_t5");
    ex(i_st, 1'b1, ro(6) | M_MDRIN, "st_t6");
    ex(i_st, 1'b0, M_MWR, "st_t7_w");
    ex(i_st, 1'b1, M_MWR, "st_t7");

    fetch(i_mul, 2);
    ex(i_mul, 1'b1, ro(5) | M_RYIN, "mul_t3");
    ex(i_mul, 1'b1, ro(6) | M_RZIN, "mul_t4");
    ex(i_mul, 1'b1, M_ZLO | M_LOIN, "mul_t5");
    ex(i_mul, 1'b1, M_ZHI | M_HIIN, "mul_t6");

    fetch(i_neg, 0);
    ex(i_neg, 1'b1, ro(8) | M_RYIN, "neg_t3");
    ex(i_neg, 1'b1, ro(8) | M_RZIN, "neg_t4");
    ex(i_neg, 1'b1, M_ZLO | ri(4), "neg_t5");

    fetch(i_addi, 0);
    ex(i_addi, 1'b1, ro(2) | M_RYIN, "addi_t3");
    ex(i_addi, 1'b1, M_COUT | M_RZIN, "addi_t4");
    ex(i_addi, 1'b1, M_ZLO | ri(1), "addi_t5");

    fetch(i_ldi, 0);
    ex(i_ldi, 1'b1, ro(9) | M_BA | M_RYIN, "ldi_t3");
    ex(i_ldi, 1'b1, M_COUT | M_RZIN, "ldi_t4");
    ex(i_ldi, 1'b1, M_ZLO | ri(5), "ldi_t5");

    fetch(i_mfhi, 0);  ex(i_mfhi, 1'b0, M_HIOUT | ri(7), "mfhi_t3");
    fetch(i_in, 0);    ex(i_in, 1'b1, M_INP | ri(10), "in_t3");
    fetch(i_out, 0);   ex(i_out, 1'b1, ro(9) | M_OUTP, "out_t3");
    fetch(i_nop, 0);   ex(i_nop, 1'b1, 64'd0, "nop_t3");
    fetch(i_undef, 0); ex(i_undef, 1'b1, 64'd0, "undef_t3");

    // reset while a store waits for memory: write strobe must drop at once
    fetch(i_st2, 0);
    ex(i_st2, 1'b1, ro(12) | M_BA | M_RYIN, "st2_t3");
    ex(i_st2, 1'b1, M_COUT | M_RZIN, "st2_t4");
    ex(i_st2, 1'b1, M_ZLO | M_MARIN, "st2_t5");
    ex(i_st2, 1'b1, ro(11) | M_MDRIN, "st2_t6");
    ex(i_st2, 1'b0, M_MWR, "st2_t7_w");
    put(1'b0, 1'b1, i_st2, 64'd0, "st2_clr");
    put(1'b0, 1'b1, i_st2, 64'd0, "st2_clr_hold");
    put(1'b1, 1'b1, i_st2, 64'd0, "st2_rel");

    fetch(i_halt, 0);
    ex(i_halt, 1'b1, 64'd0, "halt_t3");
    put(1'b1, 1'b1, i_halt, 64'd0, "halted0");
    put(1'b1, 1'b0, i_add,  64'd0, "halted1");
    put(1'b1, 1'b1, i_add,  64'd0, "halted2");
    put(1'b0, 1'b1, i_add,  64'd0, "halt_clr");
    put(1'b1, 1'b1, i_add,  64'd0, "halt_rel");
    put(1'b1, 1'b0, i_add, M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_RZIN, "r_t0");
    put(1'b1, 1'b0, i_add, M_RUN | M_ZLO | M_PCIN | M_MRD | M_MDRIN, "r_t1_wait");
    put(1'b0, 1'b0, i_add, 64'd0, "wait_clr");
    put(1'b0, 1'b1, i_add, 64'd0, "wait_clr_hold");
    put(1'b1, 1'b1, i_add, 64'd0, "wait_rel");
    fetch(i_add, 0);
    ex(i_add, 1'b1, ro(1) | M_RYIN, "add2_t3");
    ex(i_add, 1'b1, ro(2) | M_RZIN, "add2_t4");
    ex(i_add, 1'b1, M_ZLO | ri(3), "add2_t5");
    put(1'b1, 1'b1, i_add, M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_RZIN, "add2_next_t0");

    while (stim_q.size() > 0) begin
      e = stim_q.pop_front();
      t = stag_q.pop_front();
      @(posedge clock);
      #1;
      clear = e.clr; mem_ready = e.mr; ir = e.irv;
      exp_q.push_back(e.exp);
      etag_q.push_back(t);
      if (!e.clr) begin
        #1;
        chk({t, "_async"}, obs, 64'd0);
      end
    end

    @(negedge clock);
    #1;
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
